timing_acq_stats: RTL and testbench
===================================

Name: timing_acq_stats

Overview:
- Downstream consumer of the timing manager's per-sensor acquisition times and done strobes.
- Tracks acquisition cycles, starting at the manager's trigger and ending when every enabled sensor has reported done.
- Keeps per-sensor last/min/max/sample-count statistics, counts overruns (new trigger before the cycle completes), and raises a sticky interrupt with ack handshake.
- Statistics are exposed through a registered select mux for the AXI register front-end.

Parameters:
- N_SENSORS, 6, number of sensor channels (bit order: eddy0..3, encoder, adc).
- TW, 16, width of each time value.
- CW, 16, width of sample and overrun counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- trigger  in  1  cycle-start pulse from the timing manager
- en_bits  in  N_SENSORS  enabled sensors, same bit order
- done  in  N_SENSORS  raw done levels from sensors
- time_in  in  N_SENSORS*TW  flattened per-sensor times from the timing manager, sensor k at [k*TW +: TW]
- clear  in  1  pulse; resets all statistics
- sel  in  3  readout channel select
- irq_ack  in  1  pulse; clears irq
- rd_last / rd_min / rd_max  out  TW  stats of the selected channel
- rd_count  out  CW  sample count of the selected channel
- overrun_count  out  CW  number of overrun triggers
- active  out  1  cycle in progress
- irq  out  1  sticky cycle-complete interrupt

Behaviour:
- Reset values:
  - Outputs: rd_* = 0, overrun_count = 0, active = 0, irq = 0.
  - Internal: per-channel min = all-ones, max = 0, last = 0, count = 0; done_q = 0; seen = 0; state = IDLE.
- Edge detect: done_rise[k] = done[k] & ~done_q[k]; done_q is registered every cycle.
- Capture pipeline:
  - done_rise[k] in cycle N sets pend[k].
  - In cycle N+1 the block samples time_in[k], because the manager registers the time at the end of cycle N.
  - It then updates last = t, min = min(min, t), max = max(max, t), and count += 1.
  - count saturates at all-ones.
  - Capture happens only if en_bits[k] = 1 and state = ACTIVE when the rise is seen; otherwise the rise is ignored.
- FSM IDLE:
  - trigger with en_bits != 0 -> ACTIVE, seen <= 0, active <= 1.
  - trigger with en_bits == 0 is ignored.
- FSM ACTIVE:
  - seen[k] is set on each accepted done_rise[k].
  - When (seen | accepted rises this cycle) covers en_bits, go to IDLE next cycle: active <= 0, irq <= 1.
  - The final pending capture still completes one cycle later, independent of state.
- Overrun: trigger in ACTIVE increments overrun_count (saturating), clears seen, stays ACTIVE. It does not assert irq.
- Simultaneous trigger and completion in the same cycle: completion is recorded (irq <= 1), then the new cycle starts (ACTIVE, seen cleared). No overrun is counted.
- irq: set has priority over irq_ack in the same cycle; irq_ack alone clears it.
- en_bits changing mid-cycle: completion is evaluated against the current en_bits.
- clear:
  - Restores all per-channel stats to reset values and zeroes overrun_count.
  - Takes priority over a capture in the same cycle (that capture is lost).
  - Does not affect FSM, irq or seen.
- Readout: rd_* registered from sel with 1-cycle latency. sel >= N_SENSORS -> rd_last = rd_max = rd_count = 0, rd_min = all-ones.
- Width rules: unsigned compares, no wrap. A min/max tie leaves the value unchanged.
- Reset mid-cycle: everything returns to reset values immediately (asynchronous); pend is discarded.

Decomposition:
- Shared package timing_pkg:
  - Sensor index constants SNS_EDDY0..SNS_ADC (0..5).
  - N_SENSORS, TW, CW.
  - FSM state typedef (IDLE, ACTIVE).
  - TIME_MAX constant (all-ones).
- One sub-module is natural: acq_stat_channel.
  - Per-sensor edge detect, pend flag, last/min/max/count registers and clear.
  - Instantiated N_SENSORS times in a generate loop.
  - The top holds the FSM, overrun counter, irq and readout mux.

Test Plan:
1. Reset then en_bits = 6'b100000. Trigger; adc done rises 40 cycles later with time_in[adc] = 40 the next cycle -> active falls and irq = 1 one cycle after the rise. sel = 5 -> rd_last = rd_min = rd_max = 40, rd_count = 1.
2. Three ADC cycles with times 40, 25, 70 -> rd_min = 25, rd_max = 70, rd_last = 70, rd_count = 3. irq_ack clears irq; irq_ack coinciding with a completion -> irq stays 1.
3. en_bits = 6'b010011. Eddy0 and encoder done, second trigger before eddy1 -> overrun_count = 1, active stays 1, irq stays 0. All three then done -> irq = 1.
4. en_bits = 0, trigger -> active stays 0, no irq. Done rise on a disabled channel 2 while ACTIVE -> channel 2 count unchanged.
5. clear asserted in the capture cycle for eddy3 -> eddy3 rd_count = 0, rd_min = 0xFFFF, overrun_count = 0. A forced count of 0xFFFF plus one more sample -> stays 0xFFFF.
6. rst_n asserted low mid-ACTIVE with pend set -> active = 0, irq = 0, all stats at reset values immediately. sel = 7 -> rd_count = 0, rd_min = 0xFFFF.

Source files
------------

// File: rtl/timing_pkg.sv
// Shared constants and types for the timing acquisition statistics block.
// Sensor indices follow the done/en_bits bit order used by the timing manager.
package timing_pkg;

  localparam int N_SENSORS = 6;
  localparam int TW        = 16;
  localparam int CW        = 16;

  localparam int SNS_EDDY0   = 0;
  localparam int SNS_EDDY1   = 1;
  localparam int SNS_EDDY2   = 2;
  localparam int SNS_EDDY3   = 3;
  localparam int SNS_ENCODER = 4;
  localparam int SNS_ADC     = 5;

  localparam logic [TW-1:0] TIME_MAX = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } acq_state_e;

endpackage

// File: rtl/acq_stat_channel.sv
// One sensor channel: done edge detect, one-cycle capture pipeline and
// last/min/max/sample-count statistics with a synchronous clear.
module acq_stat_channel #(
  parameter int TW = timing_pkg::TW,
  parameter int CW = timing_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          done,
  input  logic          accept,
  input  logic          clear,
  input  logic [TW-1:0] time_in,
  output logic          rise_acc,
  output logic [TW-1:0] stat_last,
  output logic [TW-1:0] stat_min,
  output logic [TW-1:0] stat_max,
  output logic [CW-1:0] stat_count
);

  logic          done_q, done_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] last_q, last_d;
  logic [TW-1:0] min_q, min_d;
  logic [TW-1:0] max_q, max_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every _d takes its _q (or a safe constant) before any branch, so no path leaves it unassigned and no latch is inferred.
    done_d   = done;
    rise_acc = done & ~done_q & accept;
    pend_d   = rise_acc;
    last_d   = last_q;
    min_d    = min_q;
    max_d    = max_q;
    count_d  = count_q;
    if (clear) begin
      last_d  = '0;
      min_d   = '1;
      max_d   = '0;
      count_d = '0;
    end else if (pend_q) begin
      // The manager registers the time in the rise cycle, so it is valid here.
      last_d = time_in;
      if (time_in < min_q) min_d = time_in;
      if (time_in > max_q) max_d = time_in;
      if (count_q != '1) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the statistics are ordinary flops rather than a RAM, so they take an async reset value like any other state.
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      last_q  <= '0;
      min_q   <= '1;
      max_q   <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values regardless of statement order.
      done_q  <= done_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      min_q   <= min_d;
      max_q   <= max_d;
      count_q <= count_d;
    end
  end

  assign stat_last  = last_q;
  assign stat_min   = min_q;
  assign stat_max   = max_q;
  assign stat_count = count_q;

endmodule

// File: rtl/timing_acq_stats.sv
// Acquisition-cycle tracker: FSM, overrun counter, sticky irq and registered
// statistics readout mux over N_SENSORS acq_stat_channel instances.
module timing_acq_stats #(
  parameter int N_SENSORS = timing_pkg::N_SENSORS,
  parameter int TW        = timing_pkg::TW,
  parameter int CW        = timing_pkg::CW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    trigger,
  input  logic [N_SENSORS-1:0]    en_bits,
  input  logic [N_SENSORS-1:0]    done,
  input  logic [N_SENSORS*TW-1:0] time_in,
  input  logic                    clear,
  input  logic [2:0]              sel,
  input  logic                    irq_ack,
  output logic [TW-1:0]           rd_last,
  output logic [TW-1:0]           rd_min,
  output logic [TW-1:0]           rd_max,
  output logic [CW-1:0]           rd_count,
  output logic [CW-1:0]           overrun_count,
  output logic                    active,
  output logic                    irq
);

  import timing_pkg::*;

  acq_state_e              state_q, state_d;
  logic [N_SENSORS-1:0]    seen_q, seen_d;
  logic [CW-1:0]           overrun_q, overrun_d;
  logic                    irq_q, irq_d;
  logic                    irq_set;
  logic                    covered;
  logic                    is_active;
  logic [N_SENSORS-1:0]    acc_rise;
  logic [TW-1:0]           rd_last_q, rd_last_d;
  logic [TW-1:0]           rd_min_q, rd_min_d;
  logic [TW-1:0]           rd_max_q, rd_max_d;
  logic [CW-1:0]           rd_count_q, rd_count_d;

  logic [N_SENSORS-1:0][TW-1:0] last_w, min_w, max_w;
  logic [N_SENSORS-1:0][CW-1:0] count_w;

  assign is_active = (state_q == ACTIVE);

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_ch
    acq_stat_channel #(.TW(TW), .CW(CW)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .done       (done[g]),
      .accept     (en_bits[g] & is_active),
      .clear      (clear),
      .time_in    (time_in[g*TW +: TW]),
      .rise_acc   (acc_rise[g]),
      .stat_last  (last_w[g]),
      .stat_min   (min_w[g]),
      .stat_max   (max_w[g]),
      .stat_count (count_w[g])
    );
  end

  // Completion is judged against the current en_bits, including this cycle's rises.
  assign covered = ((seen_q | acc_rise) & en_bits) == en_bits;

  always_comb begin
    state_d   = state_q;
    seen_d    = seen_q;
    overrun_d = overrun_q;
    irq_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger && (en_bits != '0)) begin
          state_d = ACTIVE;
          seen_d  = '0;
        end
      end
      ACTIVE: begin
        seen_d = seen_q | acc_rise;
        if (covered) begin
          irq_set = 1'b1;
          // A trigger landing on completion starts the next cycle without an overrun.
          if (trigger && (en_bits != '0)) seen_d = '0;
          else                            state_d = IDLE;
        end else if (trigger) begin
          seen_d = '0;
          if (overrun_q != '1) overrun_d = overrun_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) overrun_d = '0;
    irq_d = irq_set | (irq_q & ~irq_ack);
  end

  always_comb begin
    rd_last_d  = '0;
    rd_min_d   = '1;
    rd_max_d   = '0;
    rd_count_d = '0;
    if (int'(sel) < N_SENSORS) begin
      rd_last_d  = last_w[sel];
      rd_min_d   = min_w[sel];
      rd_max_d   = max_w[sel];
      rd_count_d = count_w[sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      seen_q     <= '0;
      overrun_q  <= '0;
      irq_q      <= 1'b0;
      rd_last_q  <= '0;
      rd_min_q   <= '0;
      rd_max_q   <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      seen_q     <= seen_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
      rd_last_q  <= rd_last_d;
      rd_min_q   <= rd_min_d;
      rd_max_q   <= rd_max_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_last       = rd_last_q;
  assign rd_min        = rd_min_q;
  assign rd_max        = rd_max_q;
  assign rd_count      = rd_count_q;
  assign overrun_count = overrun_q;
  assign active        = is_active;
  assign irq           = irq_q;

endmodule

// File: tb/tb_timing_acq_stats.sv
// Directed bench for timing_acq_stats: a cycle-level behavioural model is
// compared with the DUT every cycle, plus hand-computed literal checks.
module tb_timing_acq_stats;

  logic        clk;
  logic        rst_n;
  logic        trigger;
  logic [5:0]  en_bits;
  logic [5:0]  done;
  logic [95:0] time_in;
  logic        clear;
  logic [2:0]  sel;
  logic        irq_ack;
  logic [15:0] rd_last, rd_min, rd_max, rd_count, overrun_count;
  logic        active, irq;

  timing_acq_stats u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .trigger       (trigger),
    .en_bits       (en_bits),
    .done          (done),
    .time_in       (time_in),
    .clear         (clear),
    .sel           (sel),
    .irq_ack       (irq_ack),
    .rd_last       (rd_last),
    .rd_min        (rd_min),
    .rd_max        (rd_max),
    .rd_count      (rd_count),
    .overrun_count (overrun_count),
    .active        (active),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;
  bit force_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state: what an observer of the spec expects each cycle.
  logic [15:0] m_last [0:5];
  logic [15:0] m_min  [0:5];
  logic [15:0] m_max  [0:5];
  logic [15:0] m_cnt  [0:5];
  logic [5:0]  m_prev, m_pend, m_seen;
  bit          m_active, m_irq;
  logic [15:0] m_ovr, m_rd_last, m_rd_min, m_rd_max, m_rd_cnt;

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      m_last[k] = 16'h0;
      m_min[k]  = 16'hFFFF;
      m_max[k]  = 16'h0;
      m_cnt[k]  = 16'h0;
    end
    m_prev = '0; m_pend = '0; m_seen = '0;
    m_active = 1'b0; m_irq = 1'b0; m_ovr = 16'h0;
    m_rd_last = 16'h0; m_rd_min = 16'h0; m_rd_max = 16'h0; m_rd_cnt = 16'h0;
  endtask

  task automatic model_step();
    logic [5:0]  rises, acc;
    logic [15:0] t;
    bit          irq_set;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (force_req) m_cnt[3] = 16'hFFFF;
    // The readout shows the statistics as they stood before this edge.
    if (int'(sel) < 6) begin
      m_rd_last = m_last[sel]; m_rd_min = m_min[sel];
      m_rd_max  = m_max[sel];  m_rd_cnt = m_cnt[sel];
    end else begin
      m_rd_last = 16'h0; m_rd_min = 16'hFFFF; m_rd_max = 16'h0; m_rd_cnt = 16'h0;
    end
    rises  = done & ~m_prev;
    m_prev = done;
    acc    = m_active ? (rises & en_bits) : 6'b0;
    for (int k = 0; k < 6; k++) begin
      t = time_in[k*16 +: 16];
      if (clear) begin
        m_last[k] = 16'h0; m_min[k] = 16'hFFFF; m_max[k] = 16'h0; m_cnt[k] = 16'h0;
      end else if (m_pend[k]) begin
        m_last[k] = t;
        if (t < m_min[k]) m_min[k] = t;
        if (t > m_max[k]) m_max[k] = t;
        if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
      end
    end
    m_pend  = acc;
    irq_set = 1'b0;
    if (m_active) begin
      if (((m_seen | acc) & en_bits) == en_bits) begin
        irq_set = 1'b1;
        if (trigger && en_bits != 6'b0) m_seen = 6'b0;
        else                            m_active = 1'b0;
      end else if (trigger) begin
        m_seen = 6'b0;
        if (m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
      end else begin
        m_seen = m_seen | acc;
      end
    end else if (trigger && en_bits != 6'b0) begin
      m_active = 1'b1;
      m_seen   = 6'b0;
    end
    if (clear) m_ovr = 16'h0;
    if (irq_set)      m_irq = 1'b1;
    else if (irq_ack) m_irq = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Every-cycle comparison, on the falling edge away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && rst_n) begin
        check("active",        32'(active),        32'(m_active));
        check("irq",           32'(irq),           32'(m_irq));
        check("overrun_count", 32'(overrun_count), 32'(m_ovr));
        check("rd_last",       32'(rd_last),       32'(m_rd_last));
        check("rd_min",        32'(rd_min),        32'(m_rd_min));
        check("rd_max",        32'(rd_max),        32'(m_rd_max));
        check("rd_count",      32'(rd_count),      32'(m_rd_cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_trig();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic ack_irq();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  // Done rises with a stale time; the real time arrives the following cycle.
  task automatic sensor_done(input int k, input logic [15:0] t, input bit ack);
    done[k] = 1'b1;
    time_in[k*16 +: 16] = ~t;
    irq_ack = ack;
    step();
    irq_ack = 1'b0;
    time_in[k*16 +: 16] = t;
    step();
    done[k] = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; trigger = 1'b0; en_bits = '0; done = '0; time_in = '0;
    clear = 1'b0; sel = 3'd0; irq_ack = 1'b0;
    step(3);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    check("reset_active",  32'(active),        32'd0);
    check("reset_irq",     32'(irq),           32'd0);
    check("reset_overrun", 32'(overrun_count), 32'd0);
    check("reset_rd_min",  32'(rd_min),        32'd0);

    // 1: single ADC cycle, completion one cycle after the rise
    en_bits = 6'b100000;
    pulse_trig();
    check("t1_active_set", 32'(active), 32'd1);
    step(39);
    done[5] = 1'b1;
    time_in[5*16 +: 16] = 16'hFFD7;
    step();
    check("t1_active_fall", 32'(active), 32'd0);
    check("t1_irq_set",     32'(irq),    32'd1);
    time_in[5*16 +: 16] = 16'd40;
    step();
    done[5] = 1'b0;
    sel = 3'd5;
    step();
    check("t1_rd_last",  32'(rd_last),  32'd40);
    check("t1_rd_min",   32'(rd_min),   32'd40);
    check("t1_rd_max",   32'(rd_max),   32'd40);
    check("t1_rd_count", 32'(rd_count), 32'd1);

    // 2: three samples, ack handling and ack colliding with completion
    ack_irq();
    check("t2_ack_clears", 32'(irq), 32'd0);
    pulse_trig();
    step(3);
    sensor_done(5, 16'd25, 1'b0);
    ack_irq();
    pulse_trig();
    step(2);
    sensor_done(5, 16'd70, 1'b1);
    check("t2_set_beats_ack", 32'(irq), 32'd1);
    step();
    check("t2_rd_min",   32'(rd_min),   32'd25);
    check("t2_rd_max",   32'(rd_max),   32'd70);
    check("t2_rd_last",  32'(rd_last),  32'd70);
    check("t2_rd_count", 32'(rd_count), 32'd3);

    // 3: overrun mid-cycle, then completion over three sensors
    ack_irq();
    en_bits = 6'b010011;
    pulse_trig();
    sensor_done(0, 16'd100, 1'b0);
    sensor_done(4, 16'd300, 1'b0);
    check("t3_still_active", 32'(active), 32'd1);
    pulse_trig();
    check("t3_overrun",     32'(overrun_count), 32'd1);
    check("t3_active_kept", 32'(active),        32'd1);
    check("t3_no_irq",      32'(irq),           32'd0);
    sensor_done(0, 16'd120, 1'b0);
    sensor_done(1, 16'd200, 1'b0);
    sensor_done(4, 16'd310, 1'b0);
    check("t3_irq_done", 32'(irq),    32'd1);
    check("t3_idle",     32'(active), 32'd0);
    sel = 3'd0;
    step();
    check("t3_eddy0_min",   32'(rd_min),   32'd100);
    check("t3_eddy0_last",  32'(rd_last),  32'd120);
    check("t3_eddy0_count", 32'(rd_count), 32'd2);

    // 4: empty enable mask ignored, disabled channel rise ignored
    ack_irq();
    en_bits = 6'b000000;
    pulse_trig();
    step();
    check("t4_no_start", 32'(active), 32'd0);
    check("t4_no_irq",   32'(irq),    32'd0);
    en_bits = 6'b000001;
    pulse_trig();
    sensor_done(2, 16'd77, 1'b0);
    sel = 3'd2;
    step();
    check("t4_ch2_count", 32'(rd_count), 32'd0);
    check("t4_ch2_min",   32'(rd_min),   32'd65535);
    sensor_done(0, 16'd50, 1'b0);
    check("t4_irq", 32'(irq), 32'd1);

    // 5: clear wins over a capture; count saturation
    ack_irq();
    en_bits = 6'b001000;
    pulse_trig();
    done[3] = 1'b1;
    time_in[3*16 +: 16] = 16'h1234;
    step();
    time_in[3*16 +: 16] = 16'd33;
    clear = 1'b1;
    step();
    clear = 1'b0;
    done[3] = 1'b0;
    sel = 3'd3;
    step(2);
    check("t5_cleared_count", 32'(rd_count),      32'd0);
    check("t5_cleared_min",   32'(rd_min),        32'd65535);
    check("t5_cleared_ovr",   32'(overrun_count), 32'd0);
    force u_dut.g_ch[3].u_ch.count_q = 16'hFFFF;
    force_req = 1'b1;
    step();
    release u_dut.g_ch[3].u_ch.count_q;
    force_req = 1'b0;
    pulse_trig();
    sensor_done(3, 16'd55, 1'b0);
    step();
    check("t5_sat_count", 32'(rd_count), 32'd65535);
    check("t5_sat_last",  32'(rd_last),  32'd55);

    // 6: asynchronous reset with a capture pending
    ack_irq();
    en_bits = 6'b000011;
    pulse_trig();
    done[0] = 1'b1;
    time_in[0 +: 16] = 16'd9;
    step();
    rst_n = 1'b0;
    #1;
    check("t6_active",   32'(active),        32'd0);
    check("t6_irq",      32'(irq),           32'd0);
    check("t6_overrun",  32'(overrun_count), 32'd0);
    check("t6_rd_count", 32'(rd_count),      32'd0);
    check("t6_rd_last",  32'(rd_last),       32'd0);
    done = '0;
    step(2);
    rst_n = 1'b1;
    sel = 3'd7;
    step();
    check("t6_sel7_count", 32'(rd_count), 32'd0);
    check("t6_sel7_min",   32'(rd_min),   32'd65535);
    sel = 3'd0;
    step(2);
    check("t6_pend_dropped", 32'(rd_count), 32'd0);
    sel = 3'd3;
    step();
    check("t6_ch3_count", 32'(rd_count), 32'd0);
    check("t6_ch3_min",   32'(rd_min),   32'd65535);

    cmp_en = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
